// File: rtl/mips_single_cycle_core_if.sv
// Fetch and data-memory bus between the core (master) and its instruction/data memories (slave).
interface mips_single_cycle_core_if;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] dm_q;
  logic        dm_we;
  logic [15:0] dm_address;
  logic [31:0] dm_d;

  modport master (
    input  instruction, dm_q,
    output pc_out, dm_we, dm_address, dm_d
  );

  modport slave (
    output instruction, dm_q,
    input  pc_out, dm_we, dm_address, dm_d
  );
endinterface

// File: rtl/mips_single_cycle_core.sv
// Single-cycle 32-bit MIPS-style core: one instruction fetched, decoded and retired per clock.
// External instruction fetch and data memory are reached through mips_single_cycle_core_if.
package definitions;
  localparam logic [5:0] RTYPE = 6'd0;
  localparam logic [5:0] ADDI  = 6'd1;
  localparam logic [5:0] SUBI  = 6'd2;
  localparam logic [5:0] ANDI  = 6'd3;
  localparam logic [5:0] ORI   = 6'd4;
  localparam logic [5:0] XORI  = 6'd5;
  localparam logic [5:0] LUI   = 6'd6;
  localparam logic [5:0] LLI   = 6'd7;
  localparam logic [5:0] LWR   = 6'd8;
  localparam logic [5:0] SWR   = 6'd9;
  localparam logic [5:0] LWI   = 6'd10;
  localparam logic [5:0] SWI   = 6'd11;
  localparam logic [5:0] BEQ   = 6'd12;
  localparam logic [5:0] BNE   = 6'd13;
  localparam logic [5:0] J     = 6'd14;
  localparam logic [5:0] JAL   = 6'd15;
  localparam logic [5:0] RET   = 6'd16;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLA = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
endpackage

module mips_single_cycle_core
  import definitions::*;
(
  input logic                      clk,
  input logic                      reset,
  mips_single_cycle_core_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] pc_next;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] sext_imm;
  logic [31:0] zext_imm;

  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        store;

  assign op       = bus.instruction[31:26];
  assign rs       = bus.instruction[25:21];
  assign rt       = bus.instruction[20:16];
  assign rd       = bus.instruction[15:11];
  assign shamt    = bus.instruction[10:6];
  assign func     = bus.instruction[5:0];
  assign imm      = bus.instruction[15:0];
  assign target   = bus.instruction[25:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};
  assign pc_inc   = pc + 32'd1;

  function automatic logic alu_valid(input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    if (f[5:4] == 2'b00) begin
      case (f[3:0])
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SLA, ALU_SRA: ok = 1'b1;
        default:                            ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Shifts operate on b (rt) by the shamt field; a (rs) is unused for them.
  function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] y;
    case (f)
      ALU_ADD:          y = a + b;
      ALU_SUB:          y = a - b;
      ALU_AND:          y = a & b;
      ALU_OR:           y = a | b;
      ALU_XOR:          y = a ^ b;
      ALU_SLL, ALU_SLA: y = b << sh;
      ALU_SRL:          y = b >> sh;
      ALU_SRA:          y = $unsigned($signed(b) >>> sh);
      default:          y = '0;
    endcase
    return y;
  endfunction

  always_comb begin
    pc_next = pc_inc;
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = '0;
    store   = 1'b0;
    case (op)
      RTYPE: begin
        wr_addr = rd;
        wr_en   = alu_valid(func);
        wr_data = alu(func[3:0], rs_data, rt_data, shamt);
      end
      ADDI: begin wr_en = 1'b1; wr_data = rs_data + sext_imm; end
      SUBI: begin wr_en = 1'b1; wr_data = rs_data - sext_imm; end
      ANDI: begin wr_en = 1'b1; wr_data = rs_data & zext_imm; end
      ORI:  begin wr_en = 1'b1; wr_data = rs_data | zext_imm; end
      XORI: begin wr_en = 1'b1; wr_data = rs_data ^ zext_imm; end
      LUI:  begin wr_en = 1'b1; wr_data = {imm, 16'h0000}; end
      LLI:  begin wr_en = 1'b1; wr_data = zext_imm; end
      LWR, LWI: begin wr_en = 1'b1; wr_data = bus.dm_q; end
      SWR, SWI: store = 1'b1;
      BEQ: if (rs_data == rt_data) pc_next = pc_inc + sext_imm;
      BNE: if (rs_data != rt_data) pc_next = pc_inc + sext_imm;
      J:   pc_next = {pc[31:26], target};
      JAL: begin
        pc_next = {pc[31:26], target};
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc_inc;
      end
      RET: pc_next = rs_data_r31();
      default: ;
    endcase
  end

  // Address path kept separate from the write-back mux so the load data loop stays acyclic.
  assign bus.dm_address = (op == LWR || op == SWR) ? rs_data[15:0] : imm;
  assign bus.dm_d       = rt_data;
  assign bus.dm_we      = store & ~reset;
  assign bus.pc_out     = pc;

  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  logic [31:0] r31_data;

  function automatic logic [31:0] rs_data_r31();
    return r31_data;
  endfunction

  if (1'b1) begin : regfile0
    logic [31:0] mem [0:31];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (wr_en && wr_addr != 5'd0) begin
        mem[wr_addr] <= wr_data;
      end
    end

    assign rs_data  = (rs == 5'd0) ? '0 : mem[rs];
    assign rt_data  = (rt == 5'd0) ? '0 : mem[rt];
    assign r31_data = mem[31];
  end

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Directed bench for mips_single_cycle_core: hand-computed results for each instruction class.
module tb_mips_single_cycle_core;
  import definitions::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_single_cycle_core_if bus ();

  mips_single_cycle_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] ram [0:65535];

  assign bus.dm_q = ram[bus.dm_address];

  always @(posedge clk) begin
    if (bus.dm_we) ram[bus.dm_address] <= bus.dm_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ri(input logic [5:0] o, input logic [4:0] s,
                                     input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  function automatic logic [31:0] rr(input logic [3:0] f, input logic [4:0] s,
                                     input logic [4:0] t, input logic [4:0] d,
                                     input logic [4:0] sh);
    return {RTYPE, s, t, d, sh, 2'b00, f};
  endfunction

  function automatic logic [31:0] jj(input logic [5:0] o, input logic [25:0] t);
    return {o, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] ins);
    bus.instruction = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.instruction = jj(J, 26'd5);
    @(posedge clk);
    #1;
    check("reset_pc", bus.pc_out, 32'd0);
    check("reset_r31", dut.regfile0.mem[31], 32'd0);
    check("reset_we", {31'd0, bus.dm_we}, 32'd0);
    reset = 1'b0;

    step(jj(J, 26'd18));
    check("j_pc", bus.pc_out, 32'd18);
    step(jj(JAL, 26'd24));
    check("jal_pc", bus.pc_out, 32'd24);
    check("jal_r31", dut.regfile0.mem[31], 32'd19);
    step(jj(RET, 26'd0));
    check("ret_pc", bus.pc_out, 32'd19);

    step(ri(LLI, 5'd0, 5'd1, 16'd5));
    step(ri(LLI, 5'd0, 5'd2, 16'd3));
    check("lli_r1", dut.regfile0.mem[1], 32'd5);
    check("seq_pc", bus.pc_out, 32'd21);

    step(rr(ALU_ADD, 5'd1, 5'd2, 5'd3, 5'd0));
    check("add", dut.regfile0.mem[3], 32'd8);
    step(rr(ALU_SUB, 5'd1, 5'd2, 5'd3, 5'd0));
    check("sub", dut.regfile0.mem[3], 32'd2);
    step(rr(ALU_AND, 5'd1, 5'd2, 5'd3, 5'd0));
    check("and", dut.regfile0.mem[3], 32'd1);
    step(rr(ALU_OR, 5'd1, 5'd2, 5'd3, 5'd0));
    check("or", dut.regfile0.mem[3], 32'd7);
    step(rr(ALU_XOR, 5'd1, 5'd2, 5'd3, 5'd0));
    check("xor", dut.regfile0.mem[3], 32'd6);
    step(rr(4'hF, 5'd1, 5'd2, 5'd3, 5'd0));
    check("bad_func", dut.regfile0.mem[3], 32'd6);
    step(rr(ALU_SLL, 5'd1, 5'd2, 5'd3, 5'd2));
    check("sll", dut.regfile0.mem[3], 32'd12);
    step(rr(ALU_SRL, 5'd1, 5'd2, 5'd3, 5'd2));
    check("srl", dut.regfile0.mem[3], 32'd0);
    step(ri(ADDI, 5'd0, 5'd2, 16'hFFF8));
    step(rr(ALU_SRA, 5'd1, 5'd2, 5'd3, 5'd2));
    check("sra", dut.regfile0.mem[3], 32'hFFFF_FFFE);
    step(rr(ALU_SLA, 5'd1, 5'd2, 5'd3, 5'd2));
    check("sla", dut.regfile0.mem[3], 32'hFFFF_FFE0);
    step(ri(LLI, 5'd0, 5'd2, 16'd3));

    step(ri(ADDI, 5'd1, 5'd3, 16'hFFFD));
    check("addi", dut.regfile0.mem[3], 32'd2);
    step(ri(SUBI, 5'd1, 5'd3, 16'hFFFD));
    check("subi", dut.regfile0.mem[3], 32'd8);
    step(ri(ANDI, 5'd1, 5'd3, 16'd4));
    check("andi", dut.regfile0.mem[3], 32'd4);
    step(ri(ORI, 5'd1, 5'd3, 16'd4));
    check("ori", dut.regfile0.mem[3], 32'd5);
    step(ri(XORI, 5'd1, 5'd3, 16'd4));
    check("xori", dut.regfile0.mem[3], 32'd1);
    step(ri(LUI, 5'd0, 5'd3, 16'd15));
    check("lui", dut.regfile0.mem[3], 32'h000F_0000);
    step(ri(LLI, 5'd0, 5'd3, 16'd4));
    check("lli", dut.regfile0.mem[3], 32'd4);

    step(ri(SWI, 5'd0, 5'd0, 16'd5));
    step(ri(SWI, 5'd0, 5'd0, 16'd6));
    step(ri(SWI, 5'd0, 5'd0, 16'd7));
    step(ri(LLI, 5'd0, 5'd6, 16'd6));
    step(ri(SWI, 5'd0, 5'd6, 16'd3));
    step(ri(LLI, 5'd0, 5'd6, 16'd8));
    step(ri(SWI, 5'd0, 5'd6, 16'd4));
    check("swi_pre", ram[4], 32'd8);
    step(ri(LWR, 5'd2, 5'd3, 16'd0));
    check("lwr", dut.regfile0.mem[3], 32'd6);
    step(ri(LWI, 5'd0, 5'd3, 16'd4));
    check("lwi", dut.regfile0.mem[3], 32'd8);

    bus.instruction = ri(SWR, 5'd1, 5'd2, 16'd0);
    #1;
    check("swr_we", {31'd0, bus.dm_we}, 32'd1);
    check("swr_addr", {16'd0, bus.dm_address}, 32'd5);
    check("swr_d", bus.dm_d, 32'd3);
    @(posedge clk);
    #1;
    check("swr_mem", ram[5], 32'd3);
    step(ri(SWI, 5'd0, 5'd2, 16'd6));
    check("swi_mem", ram[6], 32'd3);

    step(ri(LLI, 5'd0, 5'd4, 16'd7));
    step(ri(LLI, 5'd0, 5'd5, 16'd7));
    step(jj(J, 26'd0));
    step(ri(BEQ, 5'd4, 5'd5, 16'd15));
    check("beq_taken", bus.pc_out, 32'd16);
    step(jj(J, 26'd0));
    step(ri(BNE, 5'd4, 5'd5, 16'd15));
    check("bne_not", bus.pc_out, 32'd1);
    step(ri(LLI, 5'd0, 5'd5, 16'd8));
    step(jj(J, 26'd0));
    step(ri(BEQ, 5'd4, 5'd5, 16'd15));
    check("beq_not", bus.pc_out, 32'd1);
    step(ri(BNE, 5'd4, 5'd5, 16'hFFFE));
    check("bne_back", bus.pc_out, 32'd0);

    step(jj(6'h3F, 26'h3FF_FFFF));
    check("nop_pc", bus.pc_out, 32'd1);
    check("nop_r3", dut.regfile0.mem[3], 32'd8);

    step(ri(ADDI, 5'd1, 5'd0, 16'd5));
    check("r0_write", dut.regfile0.mem[0], 32'd0);
    step(rr(ALU_ADD, 5'd0, 5'd0, 5'd3, 5'd0));
    check("r0_read", dut.regfile0.mem[3], 32'd0);

    reset = 1'b1;
    bus.instruction = ri(SWI, 5'd0, 5'd2, 16'd7);
    #1;
    check("rst_we", {31'd0, bus.dm_we}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mem", ram[7], 32'd0);
    check("rst_pc", bus.pc_out, 32'd0);
    check("rst_r1", dut.regfile0.mem[1], 32'd0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
